// File: rtl/mem_copier_pkg.sv
// Shared defaults and FSM state type for the byte-wise memory copier.
package mem_copier_pkg;
  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
endpackage

// File: rtl/mem_copier.sv
// Byte-at-a-time memory copier: READ/WRITE per byte, ascending, pointers wrap.
// Optional constant-fill mode (WRITE only, 1 cycle/byte) under MEM_COPIER_FILL_EN.
module mem_copier
  import mem_copier_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W-1:0] len,
`ifdef MEM_COPIER_FILL_EN
  input  logic              fill_mode,
  input  logic [DATA_W-1:0] fill_value,
`endif
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] WR,
  output logic              memorywrite,
  output logic              memoryread,
  input  logic [DATA_W-1:0] RD
);

  state_t            state;
  logic [ADDR_W-1:0] src_ptr, dst_ptr, cnt;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] src_nx, dst_nx;
`ifdef MEM_COPIER_FILL_EN
  logic              fill_q;
`endif

  assign src_nx = src_ptr + ADDR_W'(1);
  assign dst_nx = dst_ptr + ADDR_W'(1);
  // Fill mode preloads the data register with fill_value, so WRITE is uniform.
  assign WR     = data_q;

  // Outputs are registered: each transition sets the strobes/addr for the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      src_ptr     <= '0;
      dst_ptr     <= '0;
      cnt         <= '0;
      data_q      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      addr        <= '0;
      memoryread  <= 1'b0;
      memorywrite <= 1'b0;
`ifdef MEM_COPIER_FILL_EN
      fill_q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          busy        <= 1'b0;
          done        <= 1'b0;
          addr        <= '0;
          memoryread  <= 1'b0;
          memorywrite <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              src_ptr <= src;
              dst_ptr <= dst;
              cnt     <= len;
`ifdef MEM_COPIER_FILL_EN
              fill_q  <= fill_mode;
              if (fill_mode) begin
                data_q      <= fill_value;
                state       <= WRITE;
                addr        <= dst;
                memorywrite <= 1'b1;
              end else begin
                state      <= READ;
                addr       <= src;
                memoryread <= 1'b1;
              end
`else
              state      <= READ;
              addr       <= src;
              memoryread <= 1'b1;
`endif
            end
          end
        end
        READ: begin
          data_q      <= RD;
          state       <= WRITE;
          addr        <= dst_ptr;
          memoryread  <= 1'b0;
          memorywrite <= 1'b1;
        end
        WRITE: begin
          src_ptr     <= src_nx;
          dst_ptr     <= dst_nx;
          cnt         <= cnt - ADDR_W'(1);
          memorywrite <= 1'b0;
          if (cnt != ADDR_W'(1)) begin
`ifdef MEM_COPIER_FILL_EN
            if (fill_q) begin
              state       <= WRITE;
              addr        <= dst_nx;
              memorywrite <= 1'b1;
            end else begin
              state      <= READ;
              addr       <= src_nx;
              memoryread <= 1'b1;
            end
`else
            state      <= READ;
            addr       <= src_nx;
            memoryread <= 1'b1;
`endif
          end else begin
            state <= DONE;
            addr  <= '0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copier.sv
// Randomized self-checking bench for mem_copier against a byte-array copy model.
// Fill-mode checks are compiled in when MEM_COPIER_FILL_EN is defined.
module tb_mem_copier;
  localparam int AW = 13;
  localparam int DW = 8;
  localparam int MSZ = 8192;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] src, dst, len;
  logic          busy, done, memorywrite, memoryread;
  logic [AW-1:0] addr;
  logic [DW-1:0] WR, RD;
`ifdef MEM_COPIER_FILL_EN
  logic          fill_mode;
  logic [DW-1:0] fill_value;
`endif

  logic [7:0] mem     [MSZ];
  logic [7:0] init_img[MSZ];
  logic [7:0] ref_mem [MSZ];
  logic       init_go;

  int n_chk  = 0;
  int n_pass = 0;

  mem_copier #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .src(src), .dst(dst), .len(len),
`ifdef MEM_COPIER_FILL_EN
    .fill_mode(fill_mode), .fill_value(fill_value),
`endif
    .busy(busy), .done(done), .addr(addr), .WR(WR),
    .memorywrite(memorywrite), .memoryread(memoryread), .RD(RD)
  );

  always #5 clk = ~clk;

  // Behavioural memory: combinational read, commit on rising edge.
  assign RD = mem[addr];
  always @(posedge clk) begin
    if (init_go) for (int i = 0; i < MSZ; i++) mem[i] <= init_img[i];
    else if (memorywrite) mem[addr] <= WR;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int mem_diffs();
    int n = 0;
    for (int i = 0; i < MSZ; i++) if (mem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  // One transfer; the sample after edge j (j=0 is the accept edge) observes cycle N+1+j.
  task automatic run_op(input string tag, input int s, input int d, input int l,
                        input bit fm, input logic [7:0] fv, input bit poke);
    int rd_n = 0, wr_n = 0, done_n = 0, done_at = -1, both = 0, ord_err = 0, bz_err = 0;
    int exp_done = fm ? l : 2 * l;
    @(negedge clk);
    src = AW'(s); dst = AW'(d); len = AW'(l); start = 1'b1;
`ifdef MEM_COPIER_FILL_EN
    fill_mode = fm; fill_value = fv;
`endif
    for (int j = 0; j < exp_done + 4; j++) begin
      @(negedge clk);
      start = (poke && j == 1) ? 1'b1 : 1'b0;
      if (memoryread) begin
        if (addr !== AW'((s + rd_n) % MSZ)) ord_err++;
        rd_n++;
      end
      if (memorywrite) begin
        if (addr !== AW'((d + wr_n) % MSZ)) ord_err++;
        wr_n++;
      end
      if (memoryread && memorywrite) both++;
      if (done) begin done_n++; done_at = j; end
      if (j <= exp_done && busy !== 1'b1) bz_err++;
      if (j > exp_done && (busy || done || memoryread || memorywrite || addr != '0)) bz_err++;
    end
    start = 1'b0;
    for (int i = 0; i < l; i++)
      ref_mem[(d + i) % MSZ] = fm ? fv : ref_mem[(s + i) % MSZ];
    chk({tag, ".done_cycle"}, done_at, exp_done);
    chk({tag, ".done_pulses"}, done_n, 1);
    chk({tag, ".reads"}, rd_n, fm ? 0 : l);
    chk({tag, ".writes"}, wr_n, l);
    chk({tag, ".addr_order"}, ord_err, 0);
    chk({tag, ".rd_wr_overlap"}, both, 0);
    chk({tag, ".busy_idle"}, bz_err, 0);
    chk({tag, ".mem"}, mem_diffs(), 0);
  endtask

  initial begin
    int s, d, l;
    for (int i = 0; i < MSZ; i++) init_img[i] = 8'($urandom);
    init_img[10] = 8'hA1; init_img[11] = 8'hB2; init_img[12] = 8'hC3;
    for (int i = 0; i < MSZ; i++) ref_mem[i] = init_img[i];
    rst = 1'b1; init_go = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
`ifdef MEM_COPIER_FILL_EN
    fill_mode = 1'b0; fill_value = '0;
`endif
    repeat (3) @(negedge clk);
    init_go = 1'b0;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.addr", addr, 0);
    chk("rst.WR", WR, 0);
    chk("rst.strobes", {memoryread, memorywrite}, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op("basic3", 10, 100, 3, 1'b0, 8'h00, 1'b0);
    chk("basic3.byte100", mem[100], 8'hA1);
    chk("basic3.byte102", mem[102], 8'hC3);
    run_op("len0", 300, 400, 0, 1'b0, 8'h00, 1'b0);
    run_op("wrap", 8190, 50, 4, 1'b0, 8'h00, 1'b0);
    run_op("busy_start", 500, 600, 6, 1'b0, 8'h00, 1'b1);

    // Abort: rst is sampled at the edge that would enter the 2nd WRITE of a len=5 copy.
    @(negedge clk);
    src = AW'(700); dst = AW'(800); len = AW'(5); start = 1'b1;
    @(negedge clk); start = 1'b0;   // READ 0
    @(negedge clk);                 // WRITE 0
    @(negedge clk); rst = 1'b1;     // READ 1
    @(negedge clk);
    chk("abort.busy", busy, 0);
    chk("abort.outs", {done, memoryread, memorywrite}, 0);
    chk("abort.addr", addr, 0);
    rst = 1'b0;
    begin
      int dn = 0;
      repeat (6) begin @(negedge clk); if (done || busy) dn++; end
      chk("abort.quiet", dn, 0);
    end
    ref_mem[800] = ref_mem[700];
    chk("abort.mem", mem_diffs(), 0);
    run_op("after_abort", 900, 950, 5, 1'b0, 8'h00, 1'b0);

    for (int k = 0; k < 12; k++) begin
      s = $urandom_range(0, MSZ - 1);
      l = $urandom_range(0, 24);
      if (k % 3 == 0) d = (s + $urandom_range(1, 4)) % MSZ;
      else if (k % 3 == 1) d = (s + MSZ - $urandom_range(1, 4)) % MSZ;
      else d = $urandom_range(0, MSZ - 1);
      run_op($sformatf("rnd%0d", k), s, d, l, 1'b0, 8'h00, (l >= 2) && $urandom_range(0, 1) == 1);
    end

`ifdef MEM_COPIER_FILL_EN
    run_op("fill", 0, 200, 4, 1'b1, 8'h5A, 1'b0);
    chk("fill.byte203", mem[203], 8'h5A);
    run_op("fill_wrap", 0, 8189, 6, 1'b1, 8'h3C, 1'b1);
    run_op("copy_after_fill", 20, 30, 3, 1'b0, 8'h00, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
